// File: rtl/imem_resp_if.sv
// Fetch handshake bundle between a core (master) and the instruction responder (slave).
// Request side is req/addr with a grant. Response side is rvalid/rdata/err.
interface imem_resp_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic                  instr_req_i;
   logic [ADDR_WIDTH-1:0] instr_addr_i;
   logic                  instr_gnt_o;
   logic                  instr_rvalid_o;
   logic [DATA_WIDTH-1:0] instr_rdata_o;
   logic                  instr_err_o;

   modport master (
      output instr_req_i, instr_addr_i,
      input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
   );

   modport slave (
      input  instr_req_i, instr_addr_i,
      output instr_gnt_o, instr_rvalid_o, instr_rdata_o, instr_err_o
   );
endinterface

// File: rtl/imem_resp_model.sv
// Instruction-memory responder: a combinational grant, then a response exactly LATENCY cycles later.
// Backpressure: the grant is withheld on stall_i or when MAX_OUTSTANDING requests are unanswered.
module imem_resp_model #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int DEPTH           = 512,
   parameter int LATENCY         = 1,
   parameter int MAX_OUTSTANDING = 2,
   parameter int FIN_COUNT       = 500
) (
   input  logic                       clk,
   input  logic                       rst,
   imem_resp_if.slave                 bus,
   input  logic                       stall_i,
   input  logic                       err_en_i,
   input  logic [ADDR_WIDTH-1:0]      err_addr_i,
   input  logic                       load_we_i,
   input  logic [$clog2(DEPTH)-1:0]   load_addr_i,
   input  logic [DATA_WIDTH-1:0]      load_data_i,
   output logic [15:0]                fetch_count_o,
   output logic                       fin_o
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   typedef struct packed {
      logic                  vld;
      logic                  err;
      logic [DATA_WIDTH-1:0] dat;
   } resp_t;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   resp_t                 r_pipe [LATENCY];
   logic [OUT_W-1:0]      r_outst;
   logic [15:0]           r_cnt;
   logic                  r_fin;

   logic                  w_gnt;
   logic                  w_rvalid;
   logic                  w_err;
   logic [IDX_W-1:0]      w_idx;
   resp_t                 w_stage_in;
   resp_t                 w_nxt_out;
   logic [15:0]           w_cnt_nxt;

   assign w_idx    = bus.instr_addr_i[IDX_W+1:2];
   assign w_err    = (|bus.instr_addr_i[1:0])
                   | (|(bus.instr_addr_i >> (IDX_W + 2)))
                   | (err_en_i & (bus.instr_addr_i == err_addr_i));
   assign w_rvalid = r_pipe[LATENCY-1].vld;

   // A response leaving this cycle frees its slot, so a full responder can still grant.
   assign w_gnt = bus.instr_req_i & ~stall_i & ~rst
                & ((r_outst < OUT_W'(MAX_OUTSTANDING)) | w_rvalid);

   always_comb begin
      w_stage_in = '0;
      if (w_gnt) begin
         w_stage_in.vld = 1'b1;
         w_stage_in.err = w_err;
         w_stage_in.dat = w_err ? '0 : r_mem[w_idx];
      end
   end

   // Entry about to reach the output stage; lets the counter move in step with rvalid.
   generate
      if (LATENCY == 1) begin : g_lat1
         assign w_nxt_out = w_stage_in;
      end else begin : g_latn
         assign w_nxt_out = r_pipe[LATENCY-2];
      end
   endgenerate

   assign w_cnt_nxt = (w_nxt_out.vld && r_cnt != 16'hFFFF) ? r_cnt + 16'd1 : r_cnt;

   always_ff @(posedge clk) begin
      if (load_we_i) r_mem[load_addr_i] <= load_data_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < LATENCY; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= w_stage_in;
         for (int i = 1; i < LATENCY; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_outst <= '0;
         r_cnt   <= '0;
         r_fin   <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_nxt_out.vld && w_cnt_nxt == 16'(FIN_COUNT)) r_fin <= 1'b1;
         if (w_gnt && !w_rvalid)      r_outst <= r_outst + 1'b1;
         else if (!w_gnt && w_rvalid) r_outst <= r_outst - 1'b1;
      end
   end

   assign bus.instr_gnt_o    = w_gnt;
   assign bus.instr_rvalid_o = w_rvalid;
   assign bus.instr_rdata_o  = r_pipe[LATENCY-1].dat;
   assign bus.instr_err_o    = r_pipe[LATENCY-1].err;
   assign fetch_count_o      = r_cnt;
   assign fin_o              = r_fin;
endmodule

// File: doc/imem_resp_model.md
# imem_resp_model

Cycle-accurate instruction-memory responder for CPU core benches. It replaces the old address-change-triggered `Instr_in` lookup with a real `instr_req`/`instr_gnt`/`instr_rvalid` handshake. Latency, outstanding depth and memory depth are parametrised, and wait-state and error injection are driven from the bench. It also keeps a fetch counter and a sticky end-of-test flag, which replace the ad-hoc instruction counter and `FIN` logic. It sits beside the core top in the bench and feeds the core's instruction port.

## Interface
- `DATA_WIDTH`, 32: instruction word width.
- `ADDR_WIDTH`, 32: fetch address width, byte address.
- `DEPTH`, 512: memory words. Must be a power of 2.
- `LATENCY`, 1: cycles from grant to rvalid. Legal range 1..8.
- `MAX_OUTSTANDING`, 2: granted-but-unanswered request limit. Legal range 1..`LATENCY`+1.
- `FIN_COUNT`, 500: response count at which `fin_o` asserts.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset; one clock; reset is synchronous and active-high.
- `instr_req_i`  in  1: core fetch request.
- `instr_addr_i`  in  `ADDR_WIDTH`: fetch byte address.
- `instr_gnt_o`  out  1: request accepted this cycle.
- `instr_rvalid_o`  out  1: response valid.
- `instr_rdata_o`  out  `DATA_WIDTH`: instruction word.
- `instr_err_o`  out  1: response carries a bus error. Qualified by rvalid.
- `stall_i`  in  1: bench wait-state. Suppresses grant.
- `err_en_i`  in  1: enable error injection.
- `err_addr_i`  in  `ADDR_WIDTH`: address that returns an error when `err_en_i`=1.
- `load_we_i`  in  1: backdoor write strobe. Replaces `$readmemh` preload.
- `load_addr_i`  in  $clog2(`DEPTH`): backdoor word index.
- `load_data_i`  in  `DATA_WIDTH`: backdoor write data.
- `fetch_count_o`  out  16: completed responses. Saturates at 0xFFFF.
- `fin_o`  out  1: sticky; set when `fetch_count_o` reaches `FIN_COUNT`.

## Operation
- Word index is `instr_addr_i[$clog2(DEPTH)+1:2]`.
- Grant: `instr_gnt_o` = `instr_req_i` & ~`stall_i` & ~`rst` & (`outstanding` < `MAX_OUTSTANDING` | `instr_rvalid_o`). It is combinational.
- When a request is granted, the following are captured into stage 0 of a `LATENCY`-deep shift pipeline:
  - valid=1;
  - err = misaligned (`addr[1:0]`≠0) | out of range (`addr>>2` ≥ `DEPTH`) | (`err_en_i` & `addr`==`err_addr_i`);
  - data = `mem[index]`, or 0 if err.
- The pipeline shifts every cycle. The last stage drives the registered outputs `instr_rvalid_o`/`instr_rdata_o`/`instr_err_o`.
- Responses are strictly in grant order. There is at most one grant and at most one response per cycle.
- Outstanding counter:
  - +1 on grant, −1 on rvalid;
  - unchanged if both happen in the same cycle;
  - never exceeds `MAX_OUTSTANDING`.
- Backdoor write: `mem[load_addr_i]` ← `load_data_i` at the clock edge. If a grant reads the same word in the same cycle, the grant captures the old data (read-before-write).
- `fetch_count_o` increments on each rvalid, including errored responses. It saturates.
- `fin_o` sets on the cycle `fetch_count_o` becomes `FIN_COUNT` and stays high until `rst`.
- Reset:
  - clears the pipeline, so in-flight responses are dropped;
  - clears the outstanding counter, `fetch_count_o` and `fin_o`;
  - does NOT clear `mem`;
  - backdoor writes during `rst` are still performed.
- `instr_req_i` deasserting while a request is in flight has no effect on pending responses.

## Timing
- Reset values: `instr_gnt_o`=0, `instr_rvalid_o`=0, `instr_rdata_o`=0, `instr_err_o`=0, `fetch_count_o`=0, `fin_o`=0.
- Grant in cycle t produces rvalid in cycle t+`LATENCY` exactly. There are no variable delays; wait-states come only from `stall_i`.
- `instr_rdata_o`/`instr_err_o` are 0 whenever `instr_rvalid_o`=0.
- Full throughput of one response per cycle is reached when `MAX_OUTSTANDING` ≥ `LATENCY`.
- With `LATENCY`=1 and `MAX_OUTSTANDING`=1, back-to-back grants are possible, because rvalid in the same cycle frees the slot.
- `fin_o` rises in the same cycle as the `FIN_COUNT`-th rvalid.

## Test plan
- **Preload and basic fetch.** Preload `mem[0..3]`=0x00500093, 0x00A00113, 0x002081B3, 0x00000013. With `LATENCY`=1, hold req at addr 0,4,8,12 on consecutive grants. Required: gnt every cycle, rvalid one cycle after each grant, data in order, err=0, `fetch_count_o`=4.
- **Latency/outstanding limit.** `LATENCY`=3, `MAX_OUTSTANDING`=2, req held high. Required: grants in cycles 0 and 1, no grant in cycle 2, rvalid in cycles 3 and 4 with grants resuming in cycle 3; the outstanding counter never reaches 3.
- **Stall.** Assert `stall_i` for 4 cycles with req high. Required: gnt=0 for those 4 cycles, no rvalid after the pipeline drains, and the first grant comes in the cycle `stall_i` drops.
- **Errors.**
  - Addr 0x6: response err=1, data=0.
  - Addr `DEPTH`*4: err=1.
  - `err_en_i`=1 with `err_addr_i`=0x10, fetch 0x10: err=1, data=0.
  - Fetch 0x14: err=0.
  - `fetch_count_o` counts all four responses.
- **Reset mid-flight and read/write collision.**
  - `LATENCY`=4: grant 2 requests, then pulse `rst` one cycle. Required: no rvalid afterwards, counters 0, `mem` intact.
  - Backdoor write to word 5 in the same cycle as a grant of addr 0x14: the response returns the old word; the next fetch of 0x14 returns the new word.
- **Finish flag.** `FIN_COUNT`=500: run 500 fetches. Required: `fin_o` rises exactly on the 500th rvalid, stays high through further fetches, and clears only on `rst`.
